clk_inv_seq_ctrl: RTL and testbench

Sequencer that safely switches the polarity of a derived clock built from the standard-cell clock inverter wrapper and a clock-select mux. On a polarity request it gates the downstream clock off, waits for the gate to settle, flips the inverter select, waits again, then re-enables the clock and reports completion. It runs on the free-running source clock and sits in the clock/reset control slice, ahead of the std cell wrappers.

---
 rtl/clk_inv_seq_pkg.sv | 22 ++
 rtl/clk_inv_seq_ctrl.sv | 99 +++++++++
 tb/tb_clk_inv_seq_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_inv_seq_pkg.sv
// Shared types and constants for the clock-polarity switch sequencer.
package clk_inv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } clk_inv_seq_state_e;

    localparam int unsigned CLK_INV_SEQ_CNT_W = 16;

    // Wait-counter width: enough bits to hold max(a, b) - 1, never below 1.
    function automatic int unsigned wait_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_inv_seq_ctrl.sv
// Clock-polarity switch sequencer: gates the derived clock off, flips the
// inverter select while gated, waits for it to settle, then re-enables.
// Optional macro CLK_INV_SEQ_CNT_EN adds the sw_cnt_o completed-flip counter.
//
// state  | meaning
// IDLE   | clock enabled, waiting for a polarity request
// GATE   | clock gated, waiting GATE_WAIT cycles before the flip
// SWITCH | one cycle in which the select takes the latched target
// SETTLE | clock still gated, waiting SETTLE_WAIT cycles after the flip
module clk_inv_seq_ctrl
    import clk_inv_seq_pkg::*;
#(
    parameter int unsigned GATE_WAIT   = 2,
    parameter int unsigned SETTLE_WAIT = 2,
    parameter logic        INIT_INV    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic inv_req_i,
    output logic busy_o,
    output logic done_o,
    output logic cg_en_o,
    output logic inv_sel_o
`ifdef CLK_INV_SEQ_CNT_EN
    ,
    output logic [CLK_INV_SEQ_CNT_W-1:0] sw_cnt_o
`endif
);

    localparam int unsigned CW = wait_cnt_width(GATE_WAIT, SETTLE_WAIT);
    localparam logic [CW-1:0] GATE_LOAD   = CW'(GATE_WAIT - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_WAIT - 1);

    clk_inv_seq_state_e state;
    logic [CW-1:0]      cnt;
    logic               target;

    // Sequencer FSM with its wait down-counter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            target    <= INIT_INV;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            cg_en_o   <= 1'b1;
            inv_sel_o <= INIT_INV;
`ifdef CLK_INV_SEQ_CNT_EN
            sw_cnt_o  <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i && !busy_o) begin
                        if (inv_req_i == inv_sel_o) begin
                            // Already at the requested polarity: acknowledge only.
                            done_o <= 1'b1;
                        end else begin
                            target  <= inv_req_i;
                            cnt     <= GATE_LOAD;
                            cg_en_o <= 1'b0;
                            busy_o  <= 1'b1;
                            state   <= GATE;
                        end
                    end
                end
                GATE: begin
                    if (cnt == '0) begin
                        state <= SWITCH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SWITCH: begin
                    inv_sel_o <= target;
                    cnt       <= SETTLE_LOAD;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        cg_en_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
`ifdef CLK_INV_SEQ_CNT_EN
                        sw_cnt_o <= sw_cnt_o + CLK_INV_SEQ_CNT_W'(1);
`endif
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_inv_seq_ctrl.sv
// Directed bench for clk_inv_seq_ctrl: default timing instance plus a
// GATE_WAIT=1 / SETTLE_WAIT=4 instance. Define CLK_INV_SEQ_CNT_EN to also
// check the flip counter.
module tb_clk_inv_seq_ctrl;
    import clk_inv_seq_pkg::*;

    logic clk;
    logic rst_n;
    logic req_a, inv_a, req_b, inv_b;
    logic busy_a, done_a, cg_a, sel_a;
    logic busy_b, done_b, cg_b, sel_b;
`ifdef CLK_INV_SEQ_CNT_EN
    logic [CLK_INV_SEQ_CNT_W-1:0] cnt_a, cnt_b;
`endif

    int vecs = 0;
    int errs = 0;

    clk_inv_seq_ctrl dut_a (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req_a),
        .inv_req_i (inv_a),
        .busy_o    (busy_a),
        .done_o    (done_a),
        .cg_en_o   (cg_a),
        .inv_sel_o (sel_a)
`ifdef CLK_INV_SEQ_CNT_EN
        ,
        .sw_cnt_o  (cnt_a)
`endif
    );

    clk_inv_seq_ctrl #(
        .GATE_WAIT   (1),
        .SETTLE_WAIT (4),
        .INIT_INV    (1'b0)
    ) dut_b (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req_b),
        .inv_req_i (inv_b),
        .busy_o    (busy_b),
        .done_o    (done_b),
        .cg_en_o   (cg_b),
        .inv_sel_o (sel_b)
`ifdef CLK_INV_SEQ_CNT_EN
        ,
        .sw_cnt_o  (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The select may only move while the gate enable was and still is low.
    logic prev_sel_a, prev_cg_a, prev_sel_b, prev_cg_b;
    initial begin
        prev_sel_a = 1'b0; prev_cg_a = 1'b1;
        prev_sel_b = 1'b0; prev_cg_b = 1'b1;
    end
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sel_a !== prev_sel_a)
            check("sel_a_moved_gated", {30'd0, prev_cg_a, cg_a}, 32'd0);
        if (rst_n === 1'b1 && sel_b !== prev_sel_b)
            check("sel_b_moved_gated", {30'd0, prev_cg_b, cg_b}, 32'd0);
        prev_sel_a = sel_a; prev_cg_a = cg_a;
        prev_sel_b = sel_b; prev_cg_b = cg_b;
    end

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; inv_a = 1'b0;
        req_b = 1'b0; inv_b = 1'b0;
        tick(); tick();
        check("rst_cg", cg_a, 1);
        check("rst_sel", sel_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
`ifdef CLK_INV_SEQ_CNT_EN
        check("rst_cnt", cnt_a, 0);
`endif
        rst_n = 1'b1;
        tick();
        check("idle_done", done_a, 0);

        // Polarity change 0 -> 1, with a request pulse while busy.
        req_a = 1'b1; inv_a = 1'b1;
        tick();                                   // E0
        req_a = 1'b0;
        check("e0_busy", busy_a, 1);
        check("e0_cg", cg_a, 0);
        req_a = 1'b1; inv_a = 1'b0;               // dropped at E1
        tick();                                   // E1
        req_a = 1'b0;
        check("e1_cg", cg_a, 0);
        tick();                                   // E2
        check("e2_sel", sel_a, 0);
        check("e2_cg", cg_a, 0);
        tick();                                   // E3
        check("e3_sel", sel_a, 1);
        check("e3_cg", cg_a, 0);
        tick();                                   // E4
        check("e4_cg", cg_a, 0);
        check("e4_done", done_a, 0);
        tick();                                   // E5
        check("e5_cg", cg_a, 1);
        check("e5_done", done_a, 1);
        check("e5_busy", busy_a, 0);
`ifdef CLK_INV_SEQ_CNT_EN
        check("e5_cnt", cnt_a, 1);
`endif
        tick();                                   // E6: busy pulse not queued
        check("drop_busy", busy_a, 0);
        check("drop_done", done_a, 0);
        check("drop_sel", sel_a, 1);

        // Same polarity, then back-to-back request in the done cycle.
        req_a = 1'b1; inv_a = 1'b1;
        tick();
        check("same_done", done_a, 1);
        check("same_cg", cg_a, 1);
        check("same_busy", busy_a, 0);
`ifdef CLK_INV_SEQ_CNT_EN
        check("same_cnt", cnt_a, 1);
`endif
        inv_a = 1'b0;
        tick();
        req_a = 1'b0;
        check("b2b_busy", busy_a, 1);
        check("b2b_cg", cg_a, 0);
        check("b2b_done", done_a, 0);
        repeat (4) tick();
        check("b2b_done_early", done_a, 0);
        tick();
        check("b2b_done_pulse", done_a, 1);
        check("b2b_sel", sel_a, 0);
`ifdef CLK_INV_SEQ_CNT_EN
        check("b2b_cnt", cnt_a, 2);
`endif

        // Reset at E0+3 of a sequence, then a fresh request.
        req_a = 1'b1; inv_a = 1'b1;
        tick();                                   // E0
        req_a = 1'b0;
        tick(); tick();                           // E1, E2
        rst_n = 1'b0;
        tick();                                   // E3 in reset
        check("mrst_cg", cg_a, 1);
        check("mrst_sel", sel_a, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
`ifdef CLK_INV_SEQ_CNT_EN
        check("mrst_cnt", cnt_a, 0);
`endif
        rst_n = 1'b1;
        tick();
        check("post_rst_sel", sel_a, 0);
        req_a = 1'b1; inv_a = 1'b1;
        tick();
        req_a = 1'b0;
        repeat (4) tick();
        check("fresh_done_early", done_a, 0);
        tick();
        check("fresh_done", done_a, 1);
        check("fresh_sel", sel_a, 1);
        check("fresh_cg", cg_a, 1);
`ifdef CLK_INV_SEQ_CNT_EN
        check("fresh_cnt", cnt_a, 1);
`endif

        // GATE_WAIT=1, SETTLE_WAIT=4 instance.
        req_b = 1'b1; inv_b = 1'b1;
        tick();                                   // E0
        req_b = 1'b0;
        check("b_e0_cg", cg_b, 0);
        check("b_e0_sel", sel_b, 0);
        tick();                                   // E1
        check("b_e1_sel", sel_b, 0);
        tick();                                   // E2
        check("b_e2_sel", sel_b, 1);
        check("b_e2_cg", cg_b, 0);
        repeat (3) tick();                        // E5
        check("b_e5_done", done_b, 0);
        check("b_e5_cg", cg_b, 0);
        tick();                                   // E6
        check("b_e6_done", done_b, 1);
        check("b_e6_cg", cg_b, 1);
        check("b_e6_busy", busy_b, 0);
        tick();
        check("b_e7_done", done_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
